write_data_separator: RTL and testbench

- Decodes the combined clock+data write stream that the controller sends to the emulator during writes. This is the write-direction counterpart of the read-side clock/data pulse generator.
- Each bit cell is about 56 master clocks at 40 MHz (720 KHz). It opens with a clock pulse; a second pulse near mid-cell means 1, no pulse means 0.
- Outputs one decoded bit per cell with a 1-cycle valid strobe, for the sector write/buffer logic.

---
 rtl/write_data_separator_if.sv | 36 +++
 rtl/write_data_separator.sv | 168 ++++++++++++++++
 tb/tb_write_data_separator.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/write_data_separator_if.sv
// Signal bundle between the controller-side write stream and the write data separator.
// The controller side drives write_gate/write_pulse_in; the separator drives the decoded outputs.
interface write_data_separator_if;
  // write_bit_valid is a one-cycle strobe with no ready/backpressure: the consumer must
  // capture write_bit in that cycle. write_bit otherwise holds its last decoded value.
  logic write_gate;
  logic write_pulse_in;
  logic write_bit;
  logic write_bit_valid;
  logic locked;
  logic clock_lost;
  logic framing_error;
  logic dbg_state;

  modport master (
    output write_gate,
    output write_pulse_in,
    input  write_bit,
    input  write_bit_valid,
    input  locked,
    input  clock_lost,
    input  framing_error,
    input  dbg_state
  );

  modport slave (
    input  write_gate,
    input  write_pulse_in,
    output write_bit,
    output write_bit_valid,
    output locked,
    output clock_lost,
    output framing_error,
    output dbg_state
  );
endinterface

// File: rtl/write_data_separator.sv
// Decodes the combined clock+data write stream into one bit per cell: a cell opens with a
// clock pulse, and a second pulse inside the data window marks the cell as a 1.
module write_data_separator #(
  parameter int DATA_WIN_LO  = 14,
  parameter int DATA_WIN_HI  = 42,
  parameter int CELL_TIMEOUT = 84
) (
  input logic                   clock,
  input logic                   reset,
  write_data_separator_if.slave bus
);

  localparam logic [7:0] WIN_LO  = 8'(DATA_WIN_LO);
  localparam logic [7:0] WIN_HI  = 8'(DATA_WIN_HI);
  localparam logic [7:0] TIMEOUT = 8'(CELL_TIMEOUT);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CELL = 1'b1
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] count_q;
  logic [7:0] count_d;
  logic [7:0] count_inc;
  logic       data_flag_q;
  logic       data_flag_d;

  logic       sync1_q;
  logic       sync2_q;
  logic       sync3_q;
  logic       pulse_edge;

  logic       ev_start;
  logic       ev_gate_off;
  logic       ev_clock;
  logic       ev_data;
  logic       ev_glitch;
  logic       ev_timeout;

  logic       bit_q;
  logic       bit_d;
  logic       valid_q;
  logic       valid_d;
  logic       locked_q;
  logic       lost_q;
  logic       lost_d;
  logic       ferr_q;
  logic       ferr_d;

  // Two flops bring the asynchronous pulse line into the clock domain; the third
  // turns any pulse width into a single rising-edge cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= bus.write_pulse_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign pulse_edge = sync2_q & ~sync3_q;
  assign count_inc  = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

  // Classify what this cycle means for the current cell, in priority order.
  always_comb begin
    ev_start    = 1'b0;
    ev_gate_off = 1'b0;
    ev_clock    = 1'b0;
    ev_data     = 1'b0;
    ev_glitch   = 1'b0;
    ev_timeout  = 1'b0;
    if (state_q == ST_IDLE) begin
      ev_start = pulse_edge & bus.write_gate;
    end else begin
      if (!bus.write_gate) begin
        ev_gate_off = 1'b1;
      end else if (pulse_edge && (count_q > WIN_HI)) begin
        ev_clock = 1'b1;
      end else if (pulse_edge && (count_q >= WIN_LO)) begin
        ev_data = 1'b1;
      end else if (pulse_edge) begin
        ev_glitch = 1'b1;
      end else if (count_q == TIMEOUT) begin
        ev_timeout = 1'b1;
      end
    end
  end

  // State register; all outputs are registered alongside it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= 8'd0;
      data_flag_q <= 1'b0;
      bit_q       <= 1'b0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      lost_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      data_flag_q <= data_flag_d;
      bit_q       <= bit_d;
      valid_q     <= valid_d;
      locked_q    <= (state_d == ST_CELL);
      lost_q      <= lost_d;
      ferr_q      <= ferr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    data_flag_d = data_flag_q;
    case (state_q)
      ST_IDLE: begin
        count_d     = 8'd0;
        data_flag_d = 1'b0;
        if (ev_start) begin
          state_d = ST_CELL;
          count_d = 8'd1;
        end
      end
      ST_CELL: begin
        if (ev_gate_off || ev_timeout) begin
          state_d     = ST_IDLE;
          count_d     = 8'd0;
          data_flag_d = 1'b0;
        end else if (ev_clock) begin
          count_d     = 8'd1;
          data_flag_d = 1'b0;
        end else begin
          count_d = count_inc;
          if (ev_data) begin
            data_flag_d = 1'b1;
          end
        end
      end
    endcase
  end

  // Output logic: a cell's bit is released by the next clock pulse or by the timeout.
  always_comb begin
    bit_d   = bit_q;
    valid_d = 1'b0;
    if (ev_clock || ev_timeout) begin
      bit_d   = data_flag_q;
      valid_d = 1'b1;
    end
    lost_d = ev_timeout;
    ferr_d = ev_glitch | (ev_data & data_flag_q);
  end

  assign bus.write_bit       = bit_q;
  assign bus.write_bit_valid = valid_q;
  assign bus.locked          = locked_q;
  assign bus.clock_lost      = lost_q;
  assign bus.framing_error   = ferr_q;
  assign bus.dbg_state       = state_q;

endmodule

// File: tb/tb_write_data_separator.sv
// Bench for write_data_separator: pulse-rise schedules are decoded by a cell-level model
// and the DUT's strobe events are compared against it, plus directed gate/reset/lock checks.
module tb_write_data_separator;

  localparam int EW      = 23;
  localparam int M_LO    = 14;
  localparam int M_HI    = 42;
  localparam int M_TOUT  = 84;
  localparam int LAT     = 3;
  localparam logic [1:0] K_VALID = 2'd0;
  localparam logic [1:0] K_FERR  = 2'd1;
  localparam logic [1:0] K_LOST  = 2'd2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  write_data_separator_if bus();

  write_data_separator #(
    .DATA_WIN_LO (M_LO),
    .DATA_WIN_HI (M_HI),
    .CELL_TIMEOUT(M_TOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  int            rise_q[$];
  int            width_q[$];
  bit            lock_hist[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  bit            mon_en = 0;
  int            mon_base = 0;
  logic          last_bit = 1'b0;
  int            hold_err = 0;

  function automatic logic [EW-1:0] ev(input int c, input logic [1:0] k, input logic b);
    logic [19:0] c20;
    c20 = 20'(c);
    return {c20, k, b};
  endfunction

  // Event monitor: records strobes relative to scenario start, and checks write_bit holds.
  always @(negedge clock) begin
    if (reset) begin
      last_bit = 1'b0;
    end else begin
      if (mon_en) begin
        if (bus.write_bit_valid) obs_q.push_back(ev(cyc - mon_base, K_VALID, bus.write_bit));
        else if (bus.write_bit !== last_bit) hold_err++;
        if (bus.framing_error) obs_q.push_back(ev(cyc - mon_base, K_FERR, 1'b0));
        if (bus.clock_lost) obs_q.push_back(ev(cyc - mon_base, K_LOST, 1'b0));
      end
      if (bus.write_bit_valid) last_bit = bus.write_bit;
    end
  end

  // Cell-level model: walk pulse rise times, classify each by its distance from the
  // cell's opening clock pulse, and schedule strobes LAT cycles after the input rise.
  function automatic void build_model();
    int   start;
    int   d;
    logic flag;
    exp_q.delete();
    start = rise_q[0];
    flag  = 1'b0;
    for (int i = 1; i < rise_q.size(); i++) begin
      d = rise_q[i] - start;
      if (d > M_TOUT) begin
        exp_q.push_back(ev(start + M_TOUT + LAT, K_VALID, flag));
        exp_q.push_back(ev(start + M_TOUT + LAT, K_LOST, 1'b0));
        start = rise_q[i];
        flag  = 1'b0;
      end else if (d > M_HI) begin
        exp_q.push_back(ev(rise_q[i] + LAT, K_VALID, flag));
        start = rise_q[i];
        flag  = 1'b0;
      end else if (d >= M_LO) begin
        if (flag) exp_q.push_back(ev(rise_q[i] + LAT, K_FERR, 1'b0));
        flag = 1'b1;
      end else begin
        exp_q.push_back(ev(rise_q[i] + LAT, K_FERR, 1'b0));
      end
    end
    exp_q.push_back(ev(start + M_TOUT + LAT, K_VALID, flag));
    exp_q.push_back(ev(start + M_TOUT + LAT, K_LOST, 1'b0));
  endfunction

  task automatic add_pulse(input int at, input int w);
    rise_q.push_back(at);
    width_q.push_back(w);
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    bus.write_gate = 1'b0;
    bus.write_pulse_in = 1'b0;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic release_reset();
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Drives the rise schedule for run_len cycles, then compares recorded events with exp_q.
  task automatic run_scenario(input string name, input int gate_off_at, input int run_len);
    logic p;
    int   n;
    obs_q.delete();
    lock_hist.delete();
    hold_err = 0;
    @(posedge clock);
    #1;
    mon_base = cyc;
    mon_en = 1'b1;
    for (int k = 0; k < run_len; k++) begin
      if (k > 0) begin
        @(posedge clock);
        #1;
      end
      lock_hist.push_back(bus.locked);
      p = 1'b0;
      foreach (rise_q[i]) if (k >= rise_q[i] && k < rise_q[i] + width_q[i]) p = 1'b1;
      bus.write_pulse_in = p;
      bus.write_gate = (gate_off_at < 0) || (k < gate_off_at);
    end
    @(negedge clock);
    mon_en = 1'b0;
    bus.write_pulse_in = 1'b0;
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s event_count: got %0d events, want %0d", name, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s event%0d: got cyc=%0d kind=%0d bit=%0d, want cyc=%0d kind=%0d bit=%0d",
                 name, i, obs_q[i][22:3], obs_q[i][2:1], obs_q[i][0],
                 exp_q[i][22:3], exp_q[i][2:1], exp_q[i][0]);
      end
    end
    n_cmp++;
    if (hold_err !== 0) begin
      n_fail++;
      $display("FAIL %s write_bit_hold: got %0d changes without valid, want 0", name, hold_err);
    end
  endtask

  task automatic test_reset();
    logic [5:0] got;
    string      nm[6];
    nm = '{"write_bit", "write_bit_valid", "locked", "clock_lost", "framing_error", "dbg_state"};
    hold_reset();
    got = {bus.write_bit, bus.write_bit_valid, bus.locked, bus.clock_lost,
           bus.framing_error, bus.dbg_state};
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (got[5-i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_%s: got %b, want 0", nm[i], got[5-i]);
      end
    end
    release_reset();
  endtask

  task automatic test_plain();
    hold_reset();
    release_reset();
    rise_q.delete();
    width_q.delete();
    for (int i = 0; i < 9; i++) add_pulse(56 * i, 12);
    build_model();
    run_scenario("plain", -1, 560);
    n_cmp++;
    if (lock_hist[2] !== 1'b0 || lock_hist[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL plain_lock_rise: got %b%b at cycles 2,3, want 01", lock_hist[2], lock_hist[3]);
    end
    n_cmp++;
    if (lock_hist[534] !== 1'b1 || lock_hist[535] !== 1'b0) begin
      n_fail++;
      $display("FAIL plain_lock_fall: got %b%b at cycles 534,535, want 10",
               lock_hist[534], lock_hist[535]);
    end
  endtask

  task automatic test_data();
    logic [7:0] want;
    int         vi;
    want = 8'b0101_1000;
    hold_reset();
    release_reset();
    rise_q.delete();
    width_q.delete();
    for (int i = 0; i < 9; i++) begin
      add_pulse(56 * i, 12);
      if (i == 1 || i == 3 || i == 4) add_pulse(56 * i + 28, 12);
    end
    build_model();
    run_scenario("data", -1, 560);
    vi = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i][2:1] == K_VALID && vi < 8) begin
        n_cmp++;
        if (obs_q[i][0] !== want[7-vi]) begin
          n_fail++;
          $display("FAIL data_bit%0d: got %b, want %b", vi, obs_q[i][0], want[7-vi]);
        end
        vi++;
      end
    end
  endtask

  task automatic test_framing();
    hold_reset();
    release_reset();
    rise_q.delete();
    width_q.delete();
    add_pulse(0, 4);
    add_pulse(6, 4);
    add_pulse(56, 4);
    add_pulse(76, 4);
    add_pulse(91, 4);
    add_pulse(112, 4);
    build_model();
    run_scenario("framing", -1, 230);
  endtask

  task automatic test_boundary();
    hold_reset();
    release_reset();
    rise_q.delete();
    width_q.delete();
    add_pulse(0, 1);
    add_pulse(13, 1);
    add_pulse(43, 1);
    add_pulse(85, 1);
    add_pulse(127, 1);
    build_model();
    run_scenario("boundary", -1, 240);
    n_cmp++;
    if (lock_hist[131] !== 1'b1 || lock_hist[213] !== 1'b1 || lock_hist[214] !== 1'b0) begin
      n_fail++;
      $display("FAIL boundary_lock: got %b%b%b at cycles 131,213,214, want 110",
               lock_hist[131], lock_hist[213], lock_hist[214]);
    end
  endtask

  task automatic test_timeout_stop();
    int ones;
    hold_reset();
    release_reset();
    rise_q.delete();
    width_q.delete();
    add_pulse(0, 12);
    add_pulse(56, 12);
    add_pulse(84, 12);
    build_model();
    run_scenario("timeout", -1, 170);
    n_cmp++;
    if (lock_hist[142] !== 1'b1 || lock_hist[143] !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_lock_fall: got %b%b at cycles 142,143, want 10",
               lock_hist[142], lock_hist[143]);
    end
    rise_q.delete();
    width_q.delete();
    add_pulse(10, 4);
    add_pulse(66, 4);
    add_pulse(80, 4);
    exp_q.delete();
    run_scenario("gate_low_idle", 0, 120);
    ones = 0;
    foreach (lock_hist[i]) if (lock_hist[i]) ones++;
    n_cmp++;
    if (ones !== 0) begin
      n_fail++;
      $display("FAIL gate_low_lock: got %0d locked cycles, want 0", ones);
    end
  endtask

  task automatic test_gate_drop();
    hold_reset();
    release_reset();
    rise_q.delete();
    width_q.delete();
    add_pulse(0, 4);
    add_pulse(28, 4);
    add_pulse(56, 4);
    exp_q.delete();
    run_scenario("gate_drop", 32, 120);
    n_cmp++;
    if (lock_hist[3] !== 1'b1 || lock_hist[32] !== 1'b1 || lock_hist[33] !== 1'b0
        || lock_hist[59] !== 1'b0) begin
      n_fail++;
      $display("FAIL gate_drop_lock: got %b%b%b%b at cycles 3,32,33,59, want 1100",
               lock_hist[3], lock_hist[32], lock_hist[33], lock_hist[59]);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] got;
    hold_reset();
    release_reset();
    rise_q.delete();
    width_q.delete();
    add_pulse(0, 4);
    add_pulse(28, 4);
    add_pulse(56, 4);
    add_pulse(84, 4);
    exp_q.delete();
    exp_q.push_back(ev(59, K_VALID, 1'b1));
    run_scenario("pre_reset", -1, 95);
    hold_reset();
    got = {bus.write_bit, bus.write_bit_valid, bus.locked, bus.clock_lost,
           bus.framing_error, bus.dbg_state};
    n_cmp++;
    if (got !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %b, want 000000", got);
    end
    release_reset();
    rise_q.delete();
    width_q.delete();
    add_pulse(0, 4);
    add_pulse(56, 4);
    add_pulse(112, 4);
    build_model();
    run_scenario("post_reset", -1, 220);
  endtask

  task automatic test_random();
    int t;
    int sel;
    string nm;
    for (int it = 0; it < 6; it++) begin
      hold_reset();
      release_reset();
      rise_q.delete();
      width_q.delete();
      t = 0;
      add_pulse(0, $urandom_range(1, 3));
      for (int c = 0, nc = $urandom_range(5, 10); c < nc; c++) begin
        case ($urandom_range(0, 4))
          1: add_pulse(t + $urandom_range(M_LO, M_HI), $urandom_range(1, 3));
          2: begin
            add_pulse(t + $urandom_range(4, 10), $urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) add_pulse(t + $urandom_range(M_LO, M_HI), $urandom_range(1, 3));
          end
          3: begin
            add_pulse(t + $urandom_range(M_LO, 25), $urandom_range(1, 3));
            add_pulse(t + $urandom_range(30, M_HI), $urandom_range(1, 3));
          end
          default: ;
        endcase
        sel = $urandom_range(0, 7);
        if (sel == 0) t += M_TOUT;
        else if (sel == 1) t += $urandom_range(M_TOUT + 1, 100);
        else t += $urandom_range(46, 62);
        add_pulse(t, $urandom_range(1, 3));
      end
      build_model();
      nm = $sformatf("random%0d", it);
      run_scenario(nm, -1, t + 110);
    end
  endtask

  initial begin
    bus.write_gate = 1'b0;
    bus.write_pulse_in = 1'b0;
    test_reset();
    test_plain();
    test_data();
    test_framing();
    test_boundary();
    test_timeout_stop();
    test_gate_drop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
